multi_color_centroid_tracker: RTL and testbench

//  Parametrised successor to the single-colour centre-of-mass locator: tracks NUM_COLORS colours per frame.

---
 rtl/multi_color_centroid_tracker.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_multi_color_centroid_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_color_centroid_tracker.sv
// rtl/multi_color_centroid_tracker.sv - per-colour centroid tracker with shared sequential divider
//
// Purpose: threshold-matches each pixel against NUM_COLORS configurable mean colours and
// accumulates X/Y/count per channel. At frame end, one restoring divider computes every
// channel's centroid in turn.
//
// Ports:
//   iCLK, iRST                 clock, synchronous active-high reset
//   iEN                        accumulate enable (gates matching only)
//   iFVAL                      frame valid; rising = frame start, falling = frame end
//   iDATA_VAL, iDATA           pixel qualifier and {R,G,B} pixel
//   iX_Cont, iY_Cont           pixel column / row
//   iCFG_WE, iCFG_SEL          config write strobe and target channel
//   iCFG_MEAN, iCFG_THRESH     channel mean colour and per-component tolerance
//   oOBJ_VAL                   per-channel object valid for the last completed frame
//   oX_POS, oY_POS             packed centroids, channel k at [k*COORD_W +: COORD_W]
//   oDONE                      one-cycle pulse when all channels have been updated
//   oBUSY                      divider FSM active
//   oOVERRUN                   one-cycle pulse when a frame end is dropped
module multi_color_centroid_tracker #(
  parameter int NUM_COLORS = 2,
  parameter int DATA_W     = 12,
  parameter int COORD_W    = 16,
  parameter int CNT_W      = 24,
  parameter int SUM_W      = 40,
  parameter int MIN_PIXELS = 64,
  localparam int SEL_W     = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
  localparam int C_W       = DATA_W / 3
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iEN,
  input  logic                          iFVAL,
  input  logic                          iDATA_VAL,
  input  logic [DATA_W-1:0]             iDATA,
  input  logic [COORD_W-1:0]            iX_Cont,
  input  logic [COORD_W-1:0]            iY_Cont,
  input  logic                          iCFG_WE,
  input  logic [SEL_W-1:0]              iCFG_SEL,
  input  logic [DATA_W-1:0]             iCFG_MEAN,
  input  logic [C_W-1:0]                iCFG_THRESH,
  output logic [NUM_COLORS-1:0]         oOBJ_VAL,
  output logic [NUM_COLORS*COORD_W-1:0] oX_POS,
  output logic [NUM_COLORS*COORD_W-1:0] oY_POS,
  output logic                          oDONE,
  output logic                          oBUSY,
  output logic                          oOVERRUN
);

  localparam int               BIT_W    = $clog2(SUM_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_COLORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_NEXT, S_DONE} state_t;

  function automatic logic [C_W-1:0] abs_diff(input logic [C_W-1:0] a, input logic [C_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic color_match(input logic [DATA_W-1:0] pix,
                                       input logic [DATA_W-1:0] mean,
                                       input logic [C_W-1:0]    thr);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (abs_diff(pix[c*C_W +: C_W], mean[c*C_W +: C_W]) > thr) ok = 1'b0;
    end
    return ok;
  endfunction

  // Frame edges. The end event is delayed one cycle so the last pixel's accumulate has landed.
  logic fval_q, fval_d, fall_q, fall_d, frame_rise;
  assign frame_rise = iFVAL & ~fval_q;

  always_comb begin
    fval_d = iFVAL;
    fall_d = fval_q & ~iFVAL;
  end

  // Configuration: writes land in staging, staging becomes active at frame start.
  logic [DATA_W-1:0] stg_mean_q [NUM_COLORS], stg_mean_d [NUM_COLORS];
  logic [C_W-1:0]    stg_thr_q  [NUM_COLORS], stg_thr_d  [NUM_COLORS];
  logic [DATA_W-1:0] act_mean_q [NUM_COLORS], act_mean_d [NUM_COLORS];
  logic [C_W-1:0]    act_thr_q  [NUM_COLORS], act_thr_d  [NUM_COLORS];

  always_comb begin
    stg_mean_d = stg_mean_q;
    stg_thr_d  = stg_thr_q;
    act_mean_d = act_mean_q;
    act_thr_d  = act_thr_q;
    if (iCFG_WE && (int'(iCFG_SEL) < NUM_COLORS)) begin
      stg_mean_d[iCFG_SEL] = iCFG_MEAN;
      stg_thr_d[iCFG_SEL]  = iCFG_THRESH;
    end
    if (frame_rise) begin
      act_mean_d = stg_mean_q;
      act_thr_d  = stg_thr_q;
    end
  end

  // Match stage. A pixel in the frame-start cycle already belongs to the new frame,
  // so it is matched against the configuration that is being activated.
  logic [NUM_COLORS-1:0] p_match_q, p_match_d;
  logic [COORD_W-1:0]    p_x_q, p_x_d, p_y_q, p_y_d;

  always_comb begin
    p_x_d = iX_Cont;
    p_y_d = iY_Cont;
    for (int k = 0; k < NUM_COLORS; k++) begin
      p_match_d[k] = iEN & iFVAL & iDATA_VAL &
                     color_match(iDATA,
                                 frame_rise ? stg_mean_q[k] : act_mean_q[k],
                                 frame_rise ? stg_thr_q[k]  : act_thr_q[k]);
    end
  end

  // Accumulators with saturation: any overflow freezes the channel and marks it for the frame.
  logic [SUM_W-1:0]      acc_x_q [NUM_COLORS], acc_x_d [NUM_COLORS];
  logic [SUM_W-1:0]      acc_y_q [NUM_COLORS], acc_y_d [NUM_COLORS];
  logic [CNT_W-1:0]      acc_cnt_q [NUM_COLORS], acc_cnt_d [NUM_COLORS];
  logic [NUM_COLORS-1:0] acc_ovf_q, acc_ovf_d;
  logic [SUM_W:0]        nx_x [NUM_COLORS], nx_y [NUM_COLORS];
  logic [CNT_W:0]        nx_cnt [NUM_COLORS];

  always_comb begin
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    acc_cnt_d = acc_cnt_q;
    acc_ovf_d = acc_ovf_q;
    for (int k = 0; k < NUM_COLORS; k++) begin
      nx_x[k]   = {1'b0, acc_x_q[k]} + (SUM_W+1)'(p_x_q);
      nx_y[k]   = {1'b0, acc_y_q[k]} + (SUM_W+1)'(p_y_q);
      nx_cnt[k] = {1'b0, acc_cnt_q[k]} + (CNT_W+1)'(1);
      if (p_match_q[k]) begin
        if (nx_x[k][SUM_W] || nx_y[k][SUM_W] || nx_cnt[k][CNT_W]) begin
          acc_ovf_d[k] = 1'b1;
        end else begin
          acc_x_d[k]   = nx_x[k][SUM_W-1:0];
          acc_y_d[k]   = nx_y[k][SUM_W-1:0];
          acc_cnt_d[k] = nx_cnt[k][CNT_W-1:0];
        end
      end
    end
    if (frame_rise || fall_q) begin
      for (int k = 0; k < NUM_COLORS; k++) begin
        acc_x_d[k]   = '0;
        acc_y_d[k]   = '0;
        acc_cnt_d[k] = '0;
      end
      acc_ovf_d = '0;
    end
  end

  // Divider operands: captured only when the divider is idle, otherwise the frame is dropped.
  state_t                state_q, state_d;
  logic [SUM_W-1:0]      op_x_q [NUM_COLORS], op_x_d [NUM_COLORS];
  logic [SUM_W-1:0]      op_y_q [NUM_COLORS], op_y_d [NUM_COLORS];
  logic [CNT_W-1:0]      op_cnt_q [NUM_COLORS], op_cnt_d [NUM_COLORS];
  logic [NUM_COLORS-1:0] op_ovf_q, op_ovf_d;

  always_comb begin
    op_x_d   = op_x_q;
    op_y_d   = op_y_q;
    op_cnt_d = op_cnt_q;
    op_ovf_d = op_ovf_q;
    if (fall_q && (state_q == S_IDLE)) begin
      op_x_d   = acc_x_q;
      op_y_d   = acc_y_q;
      op_cnt_d = acc_cnt_q;
      op_ovf_d = acc_ovf_q;
    end
  end

  // Restoring divider step. On the first bit the dividend comes straight from the operand regs.
  logic [SEL_W-1:0]             ch_q, ch_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [CNT_W-1:0]             rem_q, rem_d, rem_src, rem_step;
  logic [SUM_W-1:0]             qr_q, qr_d, div_src, qr_step;
  logic [COORD_W-1:0]           qx_q, qx_d, qy_q, qy_d;
  logic [CNT_W:0]               rem_sh;
  logic                         div_ge, ch_valid;
  logic [NUM_COLORS-1:0]        obj_val_q, obj_val_d;
  logic [NUM_COLORS*COORD_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;

  assign ch_valid = (op_cnt_q[ch_q] >= MIN_CNT) && !op_ovf_q[ch_q];

  always_comb begin
    if (bit_q == '0) begin
      div_src = (state_q == S_DIV_X) ? op_x_q[ch_q] : op_y_q[ch_q];
      rem_src = '0;
    end else begin
      div_src = qr_q;
      rem_src = rem_q;
    end
    rem_sh   = {rem_src, div_src[SUM_W-1]};
    div_ge   = rem_sh >= {1'b0, op_cnt_q[ch_q]};
    // When subtracting, the true remainder is below the divisor, so the low CNT_W bits are exact.
    rem_step = div_ge ? (rem_sh[CNT_W-1:0] - op_cnt_q[ch_q]) : rem_sh[CNT_W-1:0];
    qr_step  = {div_src[SUM_W-2:0], div_ge};
  end

  // FSM: state register is in the sequential block; next-state logic here.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall_q) state_d = S_DIV_X;
      S_DIV_X: begin
        if (!ch_valid)              state_d = S_NEXT;
        else if (bit_q == LAST_BIT) state_d = S_DIV_Y;
      end
      S_DIV_Y: if (bit_q == LAST_BIT) state_d = S_NEXT;
      S_NEXT:  state_d = (ch_q == LAST_CH) ? S_DONE : S_DIV_X;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    oBUSY    = (state_q != S_IDLE);
    oDONE    = (state_q == S_DONE);
    oOVERRUN = fall_q && (state_q != S_IDLE);
  end

  // Divider datapath and result registers.
  always_comb begin
    ch_d      = ch_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    qr_d      = qr_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    obj_val_d = obj_val_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    case (state_q)
      S_IDLE: begin
        ch_d  = '0;
        bit_d = '0;
      end
      S_DIV_X, S_DIV_Y: begin
        if (ch_valid) begin
          rem_d = rem_step;
          qr_d  = qr_step;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (state_q == S_DIV_X) qx_d = qr_step[COORD_W-1:0];
            else                    qy_d = qr_step[COORD_W-1:0];
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_NEXT: begin
        obj_val_d[ch_q]                   = ch_valid;
        x_pos_d[ch_q*COORD_W +: COORD_W]  = ch_valid ? qx_q : '0;
        y_pos_d[ch_q*COORD_W +: COORD_W]  = ch_valid ? qy_q : '0;
        if (ch_q != LAST_CH) ch_d = ch_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_q    <= 1'b0;
      fall_q    <= 1'b0;
      p_match_q <= '0;
      p_x_q     <= '0;
      p_y_q     <= '0;
      acc_ovf_q <= '0;
      op_ovf_q  <= '0;
      for (int k = 0; k < NUM_COLORS; k++) begin
        stg_mean_q[k] <= '0;
        stg_thr_q[k]  <= '0;
        act_mean_q[k] <= '0;
        act_thr_q[k]  <= '0;
        acc_x_q[k]    <= '0;
        acc_y_q[k]    <= '0;
        acc_cnt_q[k]  <= '0;
        op_x_q[k]     <= '0;
        op_y_q[k]     <= '0;
        op_cnt_q[k]   <= '0;
      end
      state_q   <= S_IDLE;
      ch_q      <= '0;
      bit_q     <= '0;
      rem_q     <= '0;
      qr_q      <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      obj_val_q <= '0;
      x_pos_q   <= '0;
      y_pos_q   <= '0;
    end else begin
      fval_q     <= fval_d;
      fall_q     <= fall_d;
      p_match_q  <= p_match_d;
      p_x_q      <= p_x_d;
      p_y_q      <= p_y_d;
      stg_mean_q <= stg_mean_d;
      stg_thr_q  <= stg_thr_d;
      act_mean_q <= act_mean_d;
      act_thr_q  <= act_thr_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_ovf_q  <= acc_ovf_d;
      op_x_q     <= op_x_d;
      op_y_q     <= op_y_d;
      op_cnt_q   <= op_cnt_d;
      op_ovf_q   <= op_ovf_d;
      state_q    <= state_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      rem_q      <= rem_d;
      qr_q       <= qr_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      obj_val_q  <= obj_val_d;
      x_pos_q    <= x_pos_d;
      y_pos_q    <= y_pos_d;
    end
  end

  assign oOBJ_VAL = obj_val_q;
  assign oX_POS   = x_pos_q;
  assign oY_POS   = y_pos_q;

endmodule

// File: tb/tb_multi_color_centroid_tracker.sv
// tb/tb_multi_color_centroid_tracker.sv - directed bench for multi_color_centroid_tracker
module tb_multi_color_centroid_tracker;
  localparam int NUM_COLORS  = 2;
  localparam int SUM_W       = 40;
  localparam int DONE_BUDGET = 2 + NUM_COLORS * (2 * SUM_W + 1) + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1, fval = 1'b0, dval = 1'b0;
  logic [11:0] data = '0;
  logic [15:0] xc = '0, yc = '0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_sel = '0;
  logic [11:0] cfg_mean = '0;
  logic [3:0]  cfg_thr = '0;
  logic [1:0]  obj_val;
  logic [31:0] x_pos, y_pos;
  logic        done, busy, overrun;

  int checks = 0, errors = 0;
  int done_cnt = 0, ovr_cnt = 0;

  multi_color_centroid_tracker dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iFVAL(fval), .iDATA_VAL(dval), .iDATA(data),
    .iX_Cont(xc), .iY_Cont(yc), .iCFG_WE(cfg_we), .iCFG_SEL(cfg_sel), .iCFG_MEAN(cfg_mean),
    .iCFG_THRESH(cfg_thr), .oOBJ_VAL(obj_val), .oX_POS(x_pos), .oY_POS(y_pos),
    .oDONE(done), .oBUSY(busy), .oOVERRUN(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sel, input logic [11:0] mean, input logic [3:0] thr);
    cfg_we = 1'b1; cfg_sel = 1'(sel); cfg_mean = mean; cfg_thr = thr;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic frame_start();
    fval = 1'b1; dval = 1'b0;
    step();
  endtask

  task automatic frame_end();
    fval = 1'b0; dval = 1'b0;
    step();
  endtask

  task automatic pixel(input int x, input int y, input logic [11:0] d);
    dval = 1'b1; data = d; xc = 16'(x); yc = 16'(y);
    step();
    dval = 1'b0;
  endtask

  task automatic block(input int x0, input int y0, input int w, input int h, input logic [11:0] d);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        pixel(x0 + xx, y0 + yy, d);
  endtask

  task automatic wait_done(output bit ok);
    int start;
    start = done_cnt;
    for (int i = 0; i < DONE_BUDGET && done_cnt == start; i++) step();
    ok = (done_cnt != start);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (obj_val !== 2'b00) begin errors++; $display("FAIL reset_val got %b expected 00", obj_val); end
    checks++; if (x_pos !== 32'd0) begin errors++; $display("FAIL reset_x got %h expected 0", x_pos); end
    checks++; if (y_pos !== 32'd0) begin errors++; $display("FAIL reset_y got %h expected 0", y_pos); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", overrun); end
  endtask

  // 8x8 red block X 100..107, Y 50..57: exactly 64 pixels (MIN_PIXELS boundary), centre 103/53.
  task automatic test_single_block();
    bit ok; int d0;
    cfg_write(0, 12'hF00, 4'd1);
    cfg_write(1, 12'h0F0, 4'd1);
    frame_start();
    pixel(0, 0, 12'hD00);
    pixel(900, 900, 12'hD00);
    en = 1'b0; pixel(1000, 1000, 12'hF00); en = 1'b1;
    block(100, 50, 8, 8, 12'hF00);
    frame_end();
    d0 = done_cnt;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_done_timeout got none expected pulse within %0d", DONE_BUDGET); end
    checks++; if (obj_val !== 2'b01) begin errors++; $display("FAIL t1_val got %b expected 01", obj_val); end
    checks++; if (x_pos[15:0] !== 16'd103) begin errors++; $display("FAIL t1_x0 got %0d expected 103", x_pos[15:0]); end
    checks++; if (y_pos[15:0] !== 16'd53) begin errors++; $display("FAIL t1_y0 got %0d expected 53", y_pos[15:0]); end
    checks++; if (x_pos[31:16] !== 16'd0 || y_pos[31:16] !== 16'd0) begin errors++; $display("FAIL t1_ch1_pos got %0d,%0d expected 0,0", x_pos[31:16], y_pos[31:16]); end
    repeat (20) step();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t1_done_count got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_two_colors();
    bit ok;
    frame_start();
    block(16, 26, 9, 9, 12'hF00);
    block(196, 146, 9, 9, 12'h1F1);
    frame_end();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_done_timeout got none expected pulse"); end
    checks++; if (obj_val !== 2'b11) begin errors++; $display("FAIL t2_val got %b expected 11", obj_val); end
    checks++; if (x_pos !== {16'd200, 16'd20}) begin errors++; $display("FAIL t2_x got %h expected %h", x_pos, {16'd200, 16'd20}); end
    checks++; if (y_pos !== {16'd150, 16'd30}) begin errors++; $display("FAIL t2_y got %h expected %h", y_pos, {16'd150, 16'd30}); end
  endtask

  task automatic test_min_pixels();
    bit ok;
    frame_start();
    block(10, 10, 7, 9, 12'hF00);
    block(46, 56, 9, 9, 12'h0F0);
    frame_end();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_done_timeout got none expected pulse"); end
    checks++; if (obj_val !== 2'b10) begin errors++; $display("FAIL t3_val got %b expected 10", obj_val); end
    checks++; if (x_pos !== {16'd50, 16'd0}) begin errors++; $display("FAIL t3_x got %h expected %h", x_pos, {16'd50, 16'd0}); end
    checks++; if (y_pos !== {16'd60, 16'd0}) begin errors++; $display("FAIL t3_y got %h expected %h", y_pos, {16'd60, 16'd0}); end
  endtask

  task automatic test_cfg_mid_frame();
    bit ok;
    frame_start();
    block(26, 36, 9, 9, 12'hF00);
    cfg_write(0, 12'h00F, 4'd1);
    block(66, 76, 9, 9, 12'h00F);
    frame_end();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4a_done_timeout got none expected pulse"); end
    checks++; if (obj_val !== 2'b01) begin errors++; $display("FAIL t4a_val got %b expected 01", obj_val); end
    checks++; if (x_pos[15:0] !== 16'd30 || y_pos[15:0] !== 16'd40) begin errors++; $display("FAIL t4a_pos got %0d,%0d expected 30,40", x_pos[15:0], y_pos[15:0]); end
    frame_start();
    block(6, 6, 9, 9, 12'hF00);
    block(86, 96, 9, 9, 12'h00F);
    frame_end();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4b_done_timeout got none expected pulse"); end
    checks++; if (obj_val !== 2'b01) begin errors++; $display("FAIL t4b_val got %b expected 01", obj_val); end
    checks++; if (x_pos[15:0] !== 16'd90 || y_pos[15:0] !== 16'd100) begin errors++; $display("FAIL t4b_pos got %0d,%0d expected 90,100", x_pos[15:0], y_pos[15:0]); end
    cfg_write(0, 12'hF00, 4'd1);
  endtask

  task automatic test_overrun();
    int d0, o0;
    frame_start();
    block(36, 41, 9, 9, 12'hF00);
    frame_end();
    d0 = done_cnt; o0 = ovr_cnt;
    frame_start();
    block(96, 96, 9, 9, 12'hF00);
    frame_end();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy got %b expected 1", busy); end
    repeat (400) step();
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL t5_overrun_count got %0d expected 1", ovr_cnt - o0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t5_done_count got %0d expected 1", done_cnt - d0); end
    checks++; if (obj_val !== 2'b01) begin errors++; $display("FAIL t5_val got %b expected 01", obj_val); end
    checks++; if (x_pos[15:0] !== 16'd40 || y_pos[15:0] !== 16'd45) begin errors++; $display("FAIL t5_pos got %0d,%0d expected 40,45", x_pos[15:0], y_pos[15:0]); end
  endtask

  task automatic test_reset_mid_division();
    bit ok; int d0;
    frame_start();
    block(56, 66, 9, 9, 12'hF00);
    frame_end();
    repeat (45) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_before got %b expected 1", busy); end
    rst = 1'b1;
    step();
    checks++; if (obj_val !== 2'b00) begin errors++; $display("FAIL t6_val got %b expected 00", obj_val); end
    checks++; if (x_pos !== 32'd0 || y_pos !== 32'd0) begin errors++; $display("FAIL t6_pos got %h,%h expected 0,0", x_pos, y_pos); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b expected 0", busy); end
    rst = 1'b0;
    d0 = done_cnt;
    repeat (200) step();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL t6_no_done got %0d expected %0d", done_cnt, d0); end
    cfg_write(0, 12'hF00, 4'd1);
    frame_start();
    block(56, 66, 9, 9, 12'hF00);
    frame_end();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_done_timeout got none expected pulse"); end
    checks++; if (obj_val !== 2'b01) begin errors++; $display("FAIL t6_after_val got %b expected 01", obj_val); end
    checks++; if (x_pos[15:0] !== 16'd60 || y_pos[15:0] !== 16'd70) begin errors++; $display("FAIL t6_after_pos got %0d,%0d expected 60,70", x_pos[15:0], y_pos[15:0]); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_two_colors();
    test_min_pixels();
    test_cfg_mid_frame();
    test_overrun();
    test_reset_mid_division();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
